ser_ddr_multi: RTL and testbench

//  Parametrised N-lane parallel-to-serial engine, successor to the fixed 10-bit single-lane serializer.

---
 rtl/ser_pkg.sv | 42 ++++
 rtl/ser_ddr_multi_if.sv | 11 +
 rtl/ser_lane.sv | 34 +++
 rtl/ser_ddr_multi.sv | 134 +++++++++++++
 tb/tb_ser_ddr_multi.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/ser_pkg.sv
// Shared types, constants and helpers for the multi-lane DDR serializer.
// PRBS7 stepping is used only when the top is built with SER_PRBS_EN.
package ser_pkg;

  localparam logic [6:0] PRBS7_SEED = 7'h7F;
  localparam int         PRBS_MAX_W = 64;

  // TMDS control-period symbols, usable as IDLE_WORD
  localparam logic [9:0] CTRL00 = 10'b1101010100;
  localparam logic [9:0] CTRL01 = 10'b0010101011;
  localparam logic [9:0] CTRL10 = 10'b0101010100;
  localparam logic [9:0] CTRL11 = 10'b1010101011;

  typedef struct packed {
    logic [PRBS_MAX_W-1:0] bits;
    logic [6:0]            state;
  } prbs7_res_t;

  function automatic int beats_of(input int word_w);
    return word_w / 2;
  endfunction

  // x^7+x^6+1, bit i of the result is the i-th generated bit
  function automatic prbs7_res_t prbs7_step(input logic [6:0] state, input int n);
    prbs7_res_t res;
    logic [6:0] s;
    logic       nb;
    res = '0;
    s   = state;
    nb  = 1'b0;
    for (int i = 0; i < PRBS_MAX_W; i++) begin
      if (i < n) begin
        nb         = s[6] ^ s[5];
        s          = {s[5:0], nb};
        res.bits[i] = nb;
      end
    end
    res.state = s;
    return res;
  endfunction

endpackage

// File: rtl/ser_ddr_multi_if.sv
// Parallel word handshake into the serializer: source is master, serializer is slave.
interface ser_ddr_multi_if #(
  parameter int DATA_W = 30
) ();
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/ser_lane.sv
// One lane: WORD_W shift register, loads a word then shifts 2 bits per clk.
// rise/fall taps come straight from flops so they can feed an ODDR2 directly.
module ser_lane #(
  parameter int WORD_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] load_word,
  output logic              rise,
  output logic              fall
);

  logic [WORD_W-1:0] sh_q, sh_d;

  always_comb begin
    sh_d = sh_q >> 2;
    if (load) begin
      sh_d = load_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign rise = sh_q[0];
  assign fall = sh_q[1];

endmodule

// File: rtl/ser_ddr_multi.sv
// N-lane parallel-to-serial engine with a one-word holding buffer and IDLE insertion.
// Optional SER_PRBS_EN adds a prbs_en input that replaces the payload with PRBS7.
module ser_ddr_multi
  import ser_pkg::*;
#(
  parameter int                NUM_CH    = 3,
  parameter int                WORD_W    = 10,
  parameter logic [WORD_W-1:0] IDLE_WORD = WORD_W'(CTRL00)
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef SER_PRBS_EN
  input  logic                 prbs_en,
`endif
  ser_ddr_multi_if.slave       bus,
  input  logic                 uf_clr,
  output logic [NUM_CH-1:0]    ser_rise,
  output logic [NUM_CH-1:0]    ser_fall,
  output logic                 frame_start,
  output logic                 underflow,
  output logic                 uf_sticky
);

  localparam int BEATS  = beats_of(WORD_W);
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int DATA_W = NUM_CH * WORD_W;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              full_q, full_d;
  logic              frame_start_q, frame_start_d;
  logic              underflow_q, underflow_d;
  logic              uf_sticky_q, uf_sticky_d;

  logic load;
  logic consume;
  logic accept;
  logic uf_event;
  logic prbs_mode;
  logic [WORD_W-1:0] lane_word [NUM_CH];

`ifdef SER_PRBS_EN
  logic [6:0]        prbs_q, prbs_d;
  logic [WORD_W-1:0] prbs_word;
  prbs7_res_t        prbs_res;

  assign prbs_mode = prbs_en;

  always_comb begin
    prbs_res  = prbs7_step(prbs_q, WORD_W);
    prbs_word = prbs_res.bits[WORD_W-1:0];
    prbs_d    = prbs_q;
    if (load && prbs_mode) begin
      prbs_d = prbs_res.state;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prbs_q <= PRBS7_SEED;
    end else begin
      prbs_q <= prbs_d;
    end
  end
`else
  assign prbs_mode = 1'b0;
`endif

  assign load     = (cnt_q == CNT_W'(BEATS - 1));
  // PRBS symbols leave the holding buffer untouched
  assign consume  = load & ~prbs_mode;
  assign bus.s_ready = ~full_q | consume;
  assign accept   = bus.s_valid & bus.s_ready;
  assign uf_event = consume & ~full_q;

  always_comb begin
    cnt_d         = load ? '0 : cnt_q + CNT_W'(1);
    hold_d        = accept ? bus.s_data : hold_q;
    full_d        = full_q;
    if (consume) begin
      full_d = 1'b0;
    end
    if (accept) begin
      full_d = 1'b1;
    end
    frame_start_d = load;
    underflow_d   = uf_event;
    uf_sticky_d   = uf_event | (uf_sticky_q & ~uf_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      hold_q        <= '0;
      full_q        <= 1'b0;
      frame_start_q <= 1'b0;
      underflow_q   <= 1'b0;
      uf_sticky_q   <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      hold_q        <= hold_d;
      full_q        <= full_d;
      frame_start_q <= frame_start_d;
      underflow_q   <= underflow_d;
      uf_sticky_q   <= uf_sticky_d;
    end
  end

  // The shift register sees the old hold on a load; a same-cycle accept never bypasses.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
`ifdef SER_PRBS_EN
    assign lane_word[gi] = prbs_mode ? prbs_word :
                           full_q    ? hold_q[gi*WORD_W +: WORD_W] : IDLE_WORD;
`else
    assign lane_word[gi] = full_q ? hold_q[gi*WORD_W +: WORD_W] : IDLE_WORD;
`endif

    ser_lane #(
      .WORD_W (WORD_W)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .load_word (lane_word[gi]),
      .rise      (ser_rise[gi]),
      .fall      (ser_fall[gi])
    );
  end

  assign frame_start = frame_start_q;
  assign underflow   = underflow_q;
  assign uf_sticky   = uf_sticky_q;

endmodule

// File: tb/tb_ser_ddr_multi.sv
// Directed bench for ser_ddr_multi (3 lanes x 10 bits), checking the serial stream beat by beat.
// Build with SER_PRBS_EN defined to also exercise the PRBS7 path.
module tb_ser_ddr_multi;

  localparam int NUM_CH = 3;
  localparam int W      = 10;
  localparam int BEATS  = 5;
  localparam int DW     = NUM_CH * W;
  localparam logic [9:0] IDLE = 10'b1101010100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uf_clr = 1'b0;
  logic [NUM_CH-1:0] ser_rise, ser_fall;
  logic frame_start, underflow, uf_sticky;
`ifdef SER_PRBS_EN
  logic prbs_en = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] tx_q [$];

  always #5 clk = ~clk;

  ser_ddr_multi_if #(.DATA_W(DW)) bus ();

  ser_ddr_multi #(
    .NUM_CH    (NUM_CH),
    .WORD_W    (W),
    .IDLE_WORD (IDLE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef SER_PRBS_EN
    .prbs_en     (prbs_en),
`endif
    .bus         (bus),
    .uf_clr      (uf_clr),
    .ser_rise    (ser_rise),
    .ser_fall    (ser_fall),
    .frame_start (frame_start),
    .underflow   (underflow),
    .uf_sticky   (uf_sticky)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; a word taken on this edge is replaced by the next queued one.
  task automatic tick();
    logic acc;
    acc = bus.s_valid && bus.s_ready;
    @(posedge clk);
    #1;
    if (acc) begin
      if (tx_q.size() > 0) bus.s_data = tx_q.pop_front();
      else bus.s_valid = 1'b0;
    end
  endtask

  function automatic logic [DW-1:0] rep(input logic [9:0] w);
    return {w, w, w};
  endfunction

  // Entered in beat 0 of a symbol, returns in beat 0 of the next.
  task automatic check_symbol(input logic [DW-1:0] exp, input logic exp_uf,
                              input logic rdy_mid, input logic rdy_ld,
                              input logic inj, input logic [DW-1:0] inj_d,
                              input string tag);
    logic [NUM_CH-1:0] er, ef;
    for (int b = 0; b < BEATS; b++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        er[k] = exp[k*W + 2*b];
        ef[k] = exp[k*W + 2*b + 1];
      end
      chk($sformatf("%s b%0d rise", tag, b), 32'(ser_rise), 32'(er));
      chk($sformatf("%s b%0d fall", tag, b), 32'(ser_fall), 32'(ef));
      chk($sformatf("%s b%0d frame_start", tag, b), 32'(frame_start), (b == 0) ? 32'd1 : 32'd0);
      if (b == 0) chk($sformatf("%s underflow", tag), 32'(underflow), 32'(exp_uf));
      if (b == 2) chk($sformatf("%s ready mid", tag), 32'(bus.s_ready), 32'(rdy_mid));
      if (b == BEATS-1) begin
        chk($sformatf("%s ready load", tag), 32'(bus.s_ready), 32'(rdy_ld));
        if (inj) begin
          bus.s_valid = 1'b1;
          bus.s_data  = inj_d;
        end
      end
      tick();
    end
    $display("symbol %s checked, expected %0h uf=%0d", tag, exp, exp_uf);
  endtask

  initial begin
    logic [4:0] r0, f0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;

    // reset state
    repeat (2) tick();
    chk("rst rise", 32'(ser_rise), 32'd0);
    chk("rst fall", 32'(ser_fall), 32'd0);
    chk("rst frame_start", 32'(frame_start), 32'd0);
    chk("rst underflow", 32'(underflow), 32'd0);
    chk("rst uf_sticky", 32'(uf_sticky), 32'd0);
    chk("rst ready", 32'(bus.s_ready), 32'd1);
    rst = 1'b0;

    // test 1: idle stream after reset, first word on the outputs from cycle 5
    for (int c = 0; c < BEATS; c++) begin
      chk($sformatf("pre c%0d rise", c), 32'(ser_rise), 32'd0);
      chk($sformatf("pre c%0d frame_start", c), 32'(frame_start), 32'd0);
      tick();
    end
    for (int b = 0; b < BEATS; b++) begin
      r0[b] = ser_rise[0];
      f0[b] = ser_fall[0];
      if (b == 0) begin
        chk("t1 first underflow", 32'(underflow), 32'd1);
        chk("t1 uf_sticky", 32'(uf_sticky), 32'd1);
        chk("t1 frame_start", 32'(frame_start), 32'd1);
      end
      tick();
    end
    chk("t1 lane0 rise seq", 32'(r0), 32'b11110);
    chk("t1 lane0 fall seq", 32'(f0), 32'b10000);
    check_symbol(rep(IDLE), 1'b1, 1'b1, 1'b1, 1'b0, '0, "t1_idle2");

    // sticky clear, then set winning over a simultaneous clear
    uf_clr = 1'b1;
    tick();
    chk("clr sticky", 32'(uf_sticky), 32'd0);
    uf_clr = 1'b0;
    repeat (3) tick();
    uf_clr = 1'b1;
    tick();
    chk("set wins sticky", 32'(uf_sticky), 32'd1);
    chk("set wins underflow", 32'(underflow), 32'd1);
    tick();
    chk("clr after set", 32'(uf_sticky), 32'd0);
    uf_clr = 1'b0;
    repeat (4) tick();

    // test 2: back-to-back words with s_valid held high
    tx_q.push_back(rep(10'h000));
    tx_q.push_back(rep(10'h2AA));
    bus.s_data  = rep(10'h3FF);
    bus.s_valid = 1'b1;
    check_symbol(rep(IDLE),   1'b1, 1'b0, 1'b1, 1'b0, '0, "t2_idle");
    check_symbol(rep(10'h3FF), 1'b0, 1'b0, 1'b1, 1'b0, '0, "t2_3ff");
    check_symbol(rep(10'h000), 1'b0, 1'b0, 1'b1, 1'b0, '0, "t2_000");
    check_symbol(rep(10'h2AA), 1'b0, 1'b1, 1'b1, 1'b0, '0, "t2_2aa");
    chk("t2 queue drained", 32'(tx_q.size()), 32'd0);

    // tests 3/4: distinct lane word presented exactly on a load with hold empty
    check_symbol(rep(IDLE), 1'b1, 1'b1, 1'b1, 1'b1, {10'h33C, 10'h0F0, 10'h155}, "t3_idle");
    check_symbol(rep(IDLE), 1'b1, 1'b0, 1'b1, 1'b0, '0, "t3_gap");
    check_symbol({10'h33C, 10'h0F0, 10'h155}, 1'b0, 1'b1, 1'b1, 1'b0, '0, "t4_lanes");

    // test 5: reset at beat 2 with a word held
    bus.s_data  = rep(10'h3FF);
    bus.s_valid = 1'b1;
    tick();
    tick();
    chk("t5 ready before rst", 32'(bus.s_ready), 32'd0);
    chk("t5 underflow before rst", 32'(uf_sticky), 32'd1);
    rst = 1'b1;
    tick();
    chk("t5 rise", 32'(ser_rise), 32'd0);
    chk("t5 fall", 32'(ser_fall), 32'd0);
    chk("t5 ready", 32'(bus.s_ready), 32'd1);
    chk("t5 uf_sticky", 32'(uf_sticky), 32'd0);
    chk("t5 frame_start", 32'(frame_start), 32'd0);
    rst = 1'b0;
    repeat (BEATS) tick();
    check_symbol(rep(IDLE), 1'b1, 1'b1, 1'b1, 1'b0, '0, "t5_restart");

`ifdef SER_PRBS_EN
    // test 6: PRBS7 from seed 7F is 0000001000 0011000010 ..., LSB first
    prbs_en     = 1'b1;
    bus.s_data  = rep(10'h3FF);
    bus.s_valid = 1'b1;
    check_symbol(rep(IDLE),   1'b1, 1'b0, 1'b0, 1'b0, '0, "t6_idle");
    check_symbol(rep(10'h040), 1'b0, 1'b0, 1'b0, 1'b0, '0, "t6_prbs0");
    prbs_en = 1'b0;
    check_symbol(rep(10'h10C), 1'b0, 1'b0, 1'b1, 1'b0, '0, "t6_prbs1");
    check_symbol(rep(10'h3FF), 1'b0, 1'b1, 1'b1, 1'b0, '0, "t6_held");
`endif

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
